cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entries per producer queue (power of two, >=2).
REQ-002 Parameter ID_WIDTH, default `ID_WIDTH, ROB label width.
REQ-003 Parameter VAL_WIDTH, default `VAL_WIDTH, result width.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst_in  in  1  reset, asynchronous, active-low.
REQ-006 rdy_in  in  1  global enable; low freezes all state.
REQ-007 flush  in  1  mispredict flush, sampled only when rdy_in high.
REQ-008 aluValid  in  1  ALU result present this cycle.
REQ-009 aluLab / aluVal  in  ID_WIDTH / VAL_WIDTH  ALU ROB label and value.
REQ-010 lsbValid  in  1  load/store buffer result present this cycle.
REQ-011 lsbLab / lsbVal  in  ID_WIDTH / VAL_WIDTH  LSB ROB label and value.
REQ-012 aluFull / lsbFull  out  1  queue full; producer must hold its result.
REQ-013 cdbReady  out  1  broadcast valid, registered.
REQ-014 cdb2lab / cdb2val  out  ID_WIDTH / VAL_WIDTH  broadcast label and value, registered.

Function
REQ-015 Each producer SHALL feed its own circular FIFO (head, tail, count); a push occurs when valid, label nonzero, rdy_in high and the queue is not full.
REQ-016 A valid input with label 0 SHALL be discarded (label 0 means "no tag" to consumers).
REQ-017 A valid input while Full is high SHALL be discarded; Full SHALL derive from the registered count only (push rejected at count==FIFO_DEPTH even with a same-cycle pop).
REQ-018 Every edge with rdy_in high SHALL pop at most one entry in total, loaded into the output registers with cdbReady=1; if nothing is pending, cdbReady SHALL be 0 and cdb2lab/cdb2val SHALL hold their values.
REQ-019 Arbitration SHALL be round-robin: when both sources have candidates, grant the source not granted last; when one has a candidate, grant it; lastGrant updates only on a grant.
REQ-020 Without bypass, latency SHALL be 2 edges: push at edge N, earliest broadcast registered at edge N+1, visible in the cycle after.
REQ-021 Head/tail pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop on one queue SHALL leave count unchanged.
REQ-022 Per-source order SHALL be preserved; no entry SHALL be broadcast twice or lost except per REQ-016/017/024.
REQ-023 rdy_in low SHALL freeze pointers, counts, lastGrant and outputs; inputs that cycle SHALL be ignored.
REQ-024 flush with rdy_in high SHALL empty both queues, force cdbReady=0 and discard same-cycle inputs; lastGrant is kept.

Reset
REQ-025 While rst_in is low: queues empty, aluFull=lsbFull=0, cdbReady=0, cdb2lab=0, cdb2val=0, lastGrant=LSB (ALU wins first tie).
REQ-026 Reset asserted mid-operation SHALL discard all pending entries immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro CDB_BYPASS_EN defined: an input accepted into an empty queue that would win arbitration that edge SHALL go straight to the output registers at edge N (latency 1) and SHALL NOT be stored in the queue.
REQ-028 Macro CDB_BYPASS_EN undefined: every accepted input SHALL pass through its queue (REQ-020).

Structure
REQ-029 ID_WIDTH, VAL_WIDTH and the grant encoding (GRANT_ALU=0, GRANT_LSB=1) SHALL live in the shared defines package used by the reservation station and ROB.
REQ-030 One sub-module, cdb_fifo (parameterised depth/width, push/pop/full/empty/count), SHALL be instantiated twice.

Verification
REQ-031 Single ALU result lab=5, val=0x1234 into idle block -> cdbReady=1 with 5/0x1234 exactly one cycle, 2 edges after push (1 with CDB_BYPASS_EN).
REQ-032 ALU and LSB valid together (labs 3, 7), both held 3 cycles -> broadcast order 3,7,3,7,3,7; no drops.
REQ-033 ALU pushes 5 back-to-back with LSB queue blocking the grant, FIFO_DEPTH=4 -> aluFull high after 4th push; 5th (lab 9) never broadcast.
REQ-034 Valid with lab=0, val=0xFFFF -> no push, cdbReady stays 0.
REQ-035 Three entries queued, flush pulsed one cycle -> cdbReady=0 next cycle, no further broadcasts, Full flags 0.
REQ-036 rdy_in low for 3 cycles with entries queued -> outputs and counts frozen; draining resumes in order when rdy_in returns high.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared defines for the CDB, reservation stations and ROB: tag/value widths
// and the grant encoding, plus the round-robin pick used by the CDB arbiter.
`ifndef ID_WIDTH
`define ID_WIDTH 5
`endif
`ifndef VAL_WIDTH
`define VAL_WIDTH 32
`endif

package cdb_arbiter_pkg;

    localparam int ID_WIDTH  = `ID_WIDTH;
    localparam int VAL_WIDTH = `VAL_WIDTH;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSB = 1'b1
    } grant_e;

    // On a tie the source that did not win last time goes next.
    function automatic grant_e rr_pick(input logic alu_cand, input logic lsb_cand,
                                       input grant_e last_grant);
        if (alu_cand && lsb_cand)
            return (last_grant == GRANT_ALU) ? GRANT_LSB : GRANT_ALU;
        else if (alu_cand)
            return GRANT_ALU;
        else if (lsb_cand)
            return GRANT_LSB;
        else
            return last_grant;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Circular queue with head/tail pointers and occupancy count. Push while full
// and pop while empty are ignored; clear_i empties the queue in one edge.
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o && !clear_i;
    assign do_pop     = pop_i && !empty_o && !clear_i;
    assign pop_data_o = mem_q[head_q];
    assign count_o    = count_q;

    // NOTE: storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[tail_q] <= push_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push)
                tail_q <= tail_q + AW'(1);
            if (do_pop)
                head_q <= head_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one queue per producer (ALU, LSB), round-robin pick,
// one registered broadcast per enabled edge. Define CDB_BYPASS_EN for 1-edge latency.
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = `ID_WIDTH,
    parameter int VAL_WIDTH  = `VAL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 aluValid,
    input  logic [ID_WIDTH-1:0]  aluLab,
    input  logic [VAL_WIDTH-1:0] aluVal,
    input  logic                 lsbValid,
    input  logic [ID_WIDTH-1:0]  lsbLab,
    input  logic [VAL_WIDTH-1:0] lsbVal,
    output logic                 aluFull,
    output logic                 lsbFull,
    output logic                 cdbReady,
    output logic [ID_WIDTH-1:0]  cdb2lab,
    output logic [VAL_WIDTH-1:0] cdb2val
);

    import cdb_arbiter_pkg::grant_e;
    import cdb_arbiter_pkg::GRANT_ALU;
    import cdb_arbiter_pkg::GRANT_LSB;
    import cdb_arbiter_pkg::rr_pick;

    localparam int EW = ID_WIDTH + VAL_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [EW-1:0] alu_head, lsb_head, win_data;
    logic [CW-1:0] alu_count, lsb_count;
    logic          alu_full, lsb_full, alu_empty, lsb_empty;
    logic          alu_acc, lsb_acc, alu_cand, lsb_cand;
    logic          alu_byp, lsb_byp, alu_push, lsb_push, alu_pop, lsb_pop;
    logic          issue, clear;
    grant_e        grant, last_grant_q;

    logic                 ready_q;
    logic [ID_WIDTH-1:0]  lab_q;
    logic [VAL_WIDTH-1:0] val_q;

    // Label 0 means "no tag" to consumers, so it is never queued.
    assign clear   = rdy_in && flush;
    assign alu_acc = rdy_in && !flush && aluValid && (aluLab != '0) && !alu_full;
    assign lsb_acc = rdy_in && !flush && lsbValid && (lsbLab != '0) && !lsb_full;

`ifdef CDB_BYPASS_EN
    assign alu_cand = !alu_empty || alu_acc;
    assign lsb_cand = !lsb_empty || lsb_acc;
`else
    assign alu_cand = !alu_empty;
    assign lsb_cand = !lsb_empty;
`endif

    assign grant = rr_pick(alu_cand, lsb_cand, last_grant_q);
    assign issue = rdy_in && !flush && (alu_cand || lsb_cand);

`ifdef CDB_BYPASS_EN
    assign alu_byp = issue && (grant == GRANT_ALU) && alu_empty;
    assign lsb_byp = issue && (grant == GRANT_LSB) && lsb_empty;
`else
    assign alu_byp = 1'b0;
    assign lsb_byp = 1'b0;
`endif

    assign alu_push = alu_acc && !alu_byp;
    assign lsb_push = lsb_acc && !lsb_byp;
    assign alu_pop  = issue && (grant == GRANT_ALU) && !alu_byp;
    assign lsb_pop  = issue && (grant == GRANT_LSB) && !lsb_byp;

    // NOTE: default assignment first so no path through the block infers a latch.
    always_comb begin
        win_data = lsb_head;
        if (grant == GRANT_ALU)
            win_data = alu_byp ? {aluLab, aluVal} : alu_head;
        else if (lsb_byp)
            win_data = {lsbLab, lsbVal};
    end

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_alu_fifo (
        .clk         (clk),
        .rst_n       (rst_in),
        .clear_i     (clear),
        .push_i      (alu_push),
        .push_data_i ({aluLab, aluVal}),
        .pop_i       (alu_pop),
        .pop_data_o  (alu_head),
        .full_o      (alu_full),
        .empty_o     (alu_empty),
        .count_o     (alu_count)
    );

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_lsb_fifo (
        .clk         (clk),
        .rst_n       (rst_in),
        .clear_i     (clear),
        .push_i      (lsb_push),
        .push_data_i ({lsbLab, lsbVal}),
        .pop_i       (lsb_pop),
        .pop_data_o  (lsb_head),
        .full_o      (lsb_full),
        .empty_o     (lsb_empty),
        .count_o     (lsb_count)
    );

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            ready_q      <= 1'b0;
            lab_q        <= '0;
            val_q        <= '0;
            last_grant_q <= GRANT_LSB;
        end else if (rdy_in) begin
            if (issue) begin
                ready_q        <= 1'b1;
                {lab_q, val_q} <= win_data;
                last_grant_q   <= grant;
            end else begin
                ready_q <= 1'b0;
            end
        end
    end

    assign aluFull  = (alu_count == FULL_CNT);
    assign lsbFull  = (lsb_count == FULL_CNT);
    assign cdbReady = ready_q;
    assign cdb2lab  = lab_q;
    assign cdb2val  = val_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default FIFO_DEPTH=4).
module tb_cdb_arbiter;

    localparam int IW = cdb_arbiter_pkg::ID_WIDTH;
    localparam int VW = cdb_arbiter_pkg::VAL_WIDTH;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk, rst_in, rdy_in, flush;
    logic          aluValid, lsbValid;
    logic [IW-1:0] aluLab, lsbLab, cdb2lab;
    logic [VW-1:0] aluVal, lsbVal, cdb2val;
    logic          aluFull, lsbFull, cdbReady;

    int            tests;
    int            fails;
    logic [IW-1:0] bc_log[$];
    logic          mon_rdy;

    cdb_arbiter dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .aluValid (aluValid),
        .aluLab   (aluLab),
        .aluVal   (aluVal),
        .lsbValid (lsbValid),
        .lsbLab   (lsbLab),
        .lsbVal   (lsbVal),
        .aluFull  (aluFull),
        .lsbFull  (lsbFull),
        .cdbReady (cdbReady),
        .cdb2lab  (cdb2lab),
        .cdb2val  (cdb2val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records each new broadcast: one per enabled edge that produced cdbReady.
    always @(posedge clk) begin
        mon_rdy = rdy_in;
        #1;
        if (rst_in && mon_rdy && cdbReady)
            bc_log.push_back(cdb2lab);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_alu(input logic v, input int lab, input int val);
        aluValid = v;
        aluLab   = IW'(lab);
        aluVal   = VW'(val);
    endtask

    task automatic set_lsb(input logic v, input int lab, input int val);
        lsbValid = v;
        lsbLab   = IW'(lab);
        lsbVal   = VW'(val);
    endtask

    task automatic idle_inputs();
        set_alu(1'b0, 0, 0);
        set_lsb(1'b0, 0, 0);
        flush  = 1'b0;
        rdy_in = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b0;
        tick(1);
        rst_in = 1'b1;
        bc_log.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b0;
        #1;
        tests++; if (cdbReady !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b want 0", cdbReady); end
        tests++; if (cdb2lab !== '0) begin fails++; $display("FAIL reset_lab: got %0h want 0", cdb2lab); end
        tests++; if (cdb2val !== '0) begin fails++; $display("FAIL reset_val: got %0h want 0", cdb2val); end
        tests++; if (aluFull !== 1'b0 || lsbFull !== 1'b0) begin
            fails++; $display("FAIL reset_full: got alu=%0b lsb=%0b want 0/0", aluFull, lsbFull);
        end
        tick(2);
        rst_in = 1'b1;
        // Load both queues, then pull reset between clock edges.
        set_alu(1'b1, 4, 'h55); set_lsb(1'b1, 6, 'h66);
        tick(1);
        set_alu(1'b1, 8, 'h88); set_lsb(1'b1, 10, 'haa);
        tick(1);
        idle_inputs();
        tests++; if (cdbReady !== 1'b1 || cdb2lab !== IW'(4)) begin
            fails++; $display("FAIL premid_bcast: got rdy=%0b lab=%0d want 1/4", cdbReady, cdb2lab);
        end
        #2;
        rst_in = 1'b0;
        #1;
        tests++; if (cdbReady !== 1'b0 || cdb2lab !== '0) begin
            fails++; $display("FAIL async_reset: got rdy=%0b lab=%0d want 0/0", cdbReady, cdb2lab);
        end
        bc_log.delete();
        tick(1);
        rst_in = 1'b1;
        tick(4);
        tests++; if (bc_log.size() != 0) begin
            fails++; $display("FAIL async_reset_drop: got %0d broadcasts want 0", bc_log.size());
        end
    endtask

    task automatic test_single();
        do_reset();
        set_alu(1'b1, 5, 'h1234);
        tick(1);
        set_alu(1'b0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            tests++; if (cdbReady !== (c == LAT)) begin
                fails++; $display("FAIL single_ready_c%0d: got %0b want %0b", c, cdbReady, (c == LAT));
            end
            if (c == LAT) begin
                tests++; if (cdb2lab !== IW'(5) || cdb2val !== VW'('h1234)) begin
                    fails++; $display("FAIL single_data: got %0d/%0h want 5/1234", cdb2lab, cdb2val);
                end
            end
            tick(1);
        end
        tests++; if (cdbReady !== 1'b0 || cdb2lab !== IW'(5) || cdb2val !== VW'('h1234)) begin
            fails++; $display("FAIL single_hold: got rdy=%0b %0d/%0h want 0 5/1234", cdbReady, cdb2lab, cdb2val);
        end
        tests++; if (bc_log.size() != 1) begin
            fails++; $display("FAIL single_count: got %0d broadcasts want 1", bc_log.size());
        end
    endtask

    task automatic test_round_robin();
        int exp_rr[6] = '{3, 7, 3, 7, 3, 7};
        do_reset();
        set_alu(1'b1, 3, 'h30);
        set_lsb(1'b1, 7, 'h70);
        tick(3);
        idle_inputs();
        tick(8);
        tests++; if (bc_log.size() != 6) begin
            fails++; $display("FAIL rr_count: got %0d want 6", bc_log.size());
        end
        for (int i = 0; i < 6; i++) begin
            logic [IW-1:0] got;
            got = (i < bc_log.size()) ? bc_log[i] : 'x;
            tests++; if (got !== IW'(exp_rr[i])) begin
                fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got, exp_rr[i]);
            end
        end
    endtask

    task automatic test_full();
        int exp_f[13] = '{1, 20, 2, 21, 3, 22, 4, 23, 5, 24, 6, 25, 7};
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            set_alu(1'b1, (e == 8) ? 9 : e, e);
            set_lsb(e <= 6, 19 + e, e);
            tick(1);
            if (e == 6) begin
                tests++; if (aluFull !== 1'b0 || lsbFull !== 1'b1) begin
                    fails++; $display("FAIL full_e6: got alu=%0b lsb=%0b want 0/1", aluFull, lsbFull);
                end
            end
            if (e == 7) begin
                tests++; if (aluFull !== 1'b1 || lsbFull !== 1'b0) begin
                    fails++; $display("FAIL full_e7: got alu=%0b lsb=%0b want 1/0", aluFull, lsbFull);
                end
            end
            if (e == 8) begin
                tests++; if (aluFull !== 1'b0) begin
                    fails++; $display("FAIL full_e8: got alu=%0b want 0", aluFull);
                end
            end
        end
        idle_inputs();
        tick(10);
        tests++; if (bc_log.size() != 13) begin
            fails++; $display("FAIL full_count: got %0d want 13", bc_log.size());
        end
        for (int i = 0; i < 13; i++) begin
            logic [IW-1:0] got;
            got = (i < bc_log.size()) ? bc_log[i] : 'x;
            tests++; if (got !== IW'(exp_f[i])) begin
                fails++; $display("FAIL full_order[%0d]: got %0d want %0d", i, got, exp_f[i]);
            end
        end
    endtask

    task automatic test_label_zero();
        do_reset();
        set_alu(1'b1, 0, 'hFFFF);
        set_lsb(1'b1, 0, 'hFFFF);
        tick(1);
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            tests++; if (cdbReady !== 1'b0) begin
                fails++; $display("FAIL lab0_ready_c%0d: got %0b want 0", c, cdbReady);
            end
            tick(1);
        end
        tests++; if (bc_log.size() != 0) begin
            fails++; $display("FAIL lab0_count: got %0d want 0", bc_log.size());
        end
    endtask

    task automatic test_flush();
        int exp_fl[3] = '{1, 30, 11};
        do_reset();
        set_alu(1'b1, 1, 'h1); set_lsb(1'b1, 20, 'h20);
        tick(1);
        set_alu(1'b1, 2, 'h2); set_lsb(1'b1, 21, 'h21);
        tick(1);
        tests++; if (cdbReady !== 1'b1 || cdb2lab !== IW'(1)) begin
            fails++; $display("FAIL flush_pre: got rdy=%0b lab=%0d want 1/1", cdbReady, cdb2lab);
        end
        flush = 1'b1;
        set_alu(1'b1, 3, 'h3); set_lsb(1'b1, 22, 'h22);
        tick(1);
        idle_inputs();
        tests++; if (cdbReady !== 1'b0) begin
            fails++; $display("FAIL flush_ready: got %0b want 0", cdbReady);
        end
        tests++; if (aluFull !== 1'b0 || lsbFull !== 1'b0) begin
            fails++; $display("FAIL flush_full: got alu=%0b lsb=%0b want 0/0", aluFull, lsbFull);
        end
        tick(5);
        tests++; if (cdbReady !== 1'b0 || bc_log.size() != 1) begin
            fails++; $display("FAIL flush_quiet: got rdy=%0b count=%0d want 0/1", cdbReady, bc_log.size());
        end
        // Last grant before the flush was ALU, so LSB wins the next tie.
        set_alu(1'b1, 11, 'hb); set_lsb(1'b1, 30, 'h30);
        tick(1);
        idle_inputs();
        tick(4);
        tests++; if (bc_log.size() != 3) begin
            fails++; $display("FAIL flush_after_count: got %0d want 3", bc_log.size());
        end
        for (int i = 0; i < 3; i++) begin
            logic [IW-1:0] got;
            got = (i < bc_log.size()) ? bc_log[i] : 'x;
            tests++; if (got !== IW'(exp_fl[i])) begin
                fails++; $display("FAIL flush_order[%0d]: got %0d want %0d", i, got, exp_fl[i]);
            end
        end
    endtask

    task automatic test_freeze();
        int exp_fz[4] = '{1, 20, 2, 21};
        do_reset();
        set_alu(1'b1, 1, 'h1); set_lsb(1'b1, 20, 'h20);
        tick(1);
        set_alu(1'b1, 2, 'h2); set_lsb(1'b1, 21, 'h21);
        tick(1);
        rdy_in = 1'b0;
        set_alu(1'b1, 30, 'h30); set_lsb(1'b1, 31, 'h31);
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            tests++; if (cdbReady !== 1'b1 || cdb2lab !== IW'(1)) begin
                fails++; $display("FAIL freeze_c%0d: got rdy=%0b lab=%0d want 1/1", c, cdbReady, cdb2lab);
            end
        end
        tests++; if (aluFull !== 1'b0 || lsbFull !== 1'b0) begin
            fails++; $display("FAIL freeze_full: got alu=%0b lsb=%0b want 0/0", aluFull, lsbFull);
        end
        idle_inputs();
        tick(5);
        tests++; if (bc_log.size() != 4) begin
            fails++; $display("FAIL freeze_count: got %0d want 4", bc_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            logic [IW-1:0] got;
            got = (i < bc_log.size()) ? bc_log[i] : 'x;
            tests++; if (got !== IW'(exp_fz[i])) begin
                fails++; $display("FAIL freeze_order[%0d]: got %0d want %0d", i, got, exp_fz[i]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_label_zero();
        test_flush();
        test_freeze();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
